// File: rtl/sberday_pkg.sv
// Shared defaults and FSM encoding for the logo mover.
package sberday_pkg;
   localparam int H_RES_DEF      = 640;
   localparam int V_RES_DEF      = 480;
   localparam int LOGO_SIZE_DEF  = 128;
   localparam int DEADZONE_DEF   = 256;
   localparam int STEP_SHIFT_DEF = 8;
   localparam int ADC_CENTRE     = 2048;

   typedef enum logic [1:0] {
      IDLE,
      SAMPLE,
      CALC,
      UPDATE
   } state_t;
endpackage

// File: rtl/logo_axis_step.sv
// One axis: joystick deadzone, shift to pixels, then clamp (or wrap when
// LOGO_MOVER_WRAP_EN is defined) into 0..MAX.
module logo_axis_step
   import sberday_pkg::*;
#(
   parameter int W          = 10,
   parameter int MAX        = 512,
   parameter int DEADZONE   = DEADZONE_DEF,
   parameter int STEP_SHIFT = STEP_SHIFT_DEF,
   parameter bit INVERT     = 1'b0
) (
   input  logic [11:0]  sample,
   input  logic         move_en,
   input  logic [W-1:0] pos,
   output logic [W-1:0] pos_nx
);
   localparam logic signed [12:0] CTR   = 13'(ADC_CENTRE);
   localparam logic signed [12:0] DZ    = 13'(DEADZONE);
   localparam logic signed [11:0] MAX_S = 12'(MAX);
   localparam logic signed [11:0] SPAN  = 12'(MAX + 1);

   logic signed [12:0] d;
   logic signed [12:0] mag;
   logic signed [11:0] step;
   logic signed [11:0] base;
   logic signed [11:0] sum;

   always_comb begin
      d    = signed'({1'b0, sample}) - CTR;
      mag  = d[12] ? -d : d;
      step = '0;
      if (move_en && (mag > DZ)) begin
         step = 12'(d >>> STEP_SHIFT);
      end
      if (INVERT) begin
         step = -step;
      end
      base = signed'({{(12-W){1'b0}}, pos});
      sum  = base + step;
`ifdef LOGO_MOVER_WRAP_EN
      if (sum < 0) begin
         pos_nx = W'(sum + SPAN);
      end else if (sum > MAX_S) begin
         pos_nx = W'(sum - SPAN);
      end else begin
         pos_nx = W'(sum);
      end
`else
      if (sum < 0) begin
         pos_nx = '0;
      end else if (sum > MAX_S) begin
         pos_nx = W'(MAX);
      end else begin
         pos_nx = W'(sum);
      end
`endif
   end
endmodule

// File: rtl/logo_mover.sv
// Moves a square logo once per frame from joystick samples.
// Define LOGO_MOVER_WRAP_EN for toroidal motion instead of clamping.
module logo_mover
   import sberday_pkg::*;
#(
   parameter int H_RES      = H_RES_DEF,
   parameter int V_RES      = V_RES_DEF,
   parameter int LOGO_SIZE  = LOGO_SIZE_DEF,
   parameter int DEADZONE   = DEADZONE_DEF,
   parameter int STEP_SHIFT = STEP_SHIFT_DEF
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        v_sync,
   input  logic [11:0] joystick_data_x,
   input  logic [11:0] joystick_data_y,
   input  logic        move_en,
   input  logic        recenter,
   output logic [9:0]  pos_col,
   output logic [8:0]  pos_row,
   output logic        upd_o
);
   localparam int COL_MAX = H_RES - LOGO_SIZE;
   localparam int ROW_MAX = V_RES - LOGO_SIZE;
   localparam logic [9:0] COL_CTR = 10'(COL_MAX / 2);
   localparam logic [8:0] ROW_CTR = 9'(ROW_MAX / 2);

   state_t      state;
   state_t      state_nx;
   logic        vs_q;
   logic        tick;
   logic        pend;
   logic [11:0] smp_x;
   logic [11:0] smp_y;
   logic [9:0]  col_nx;
   logic [8:0]  row_nx;

   assign tick = vs_q & ~v_sync;

   logo_axis_step #(
      .W(10), .MAX(COL_MAX), .DEADZONE(DEADZONE),
      .STEP_SHIFT(STEP_SHIFT), .INVERT(1'b0)
   ) u_col (
      .sample(smp_x), .move_en(move_en),
      .pos(pos_col), .pos_nx(col_nx)
   );

   logo_axis_step #(
      .W(9), .MAX(ROW_MAX), .DEADZONE(DEADZONE),
      .STEP_SHIFT(STEP_SHIFT), .INVERT(1'b1)
   ) u_row (
      .sample(smp_y), .move_en(move_en),
      .pos(pos_row), .pos_nx(row_nx)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (tick) state_nx = SAMPLE;
         SAMPLE:  state_nx = CALC;
         CALC:    state_nx = UPDATE;
         UPDATE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Positions are written on the edge into UPDATE so they are visible
   // together with upd_o for the whole UPDATE cycle.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state   <= IDLE;
         vs_q    <= 1'b1;
         pend    <= 1'b0;
         upd_o   <= 1'b0;
         pos_col <= COL_CTR;
         pos_row <= ROW_CTR;
         smp_x   <= 12'(ADC_CENTRE);
         smp_y   <= 12'(ADC_CENTRE);
      end else begin
         state <= state_nx;
         vs_q  <= v_sync;
         upd_o <= (state == CALC);
         if (state == SAMPLE) begin
            smp_x <= joystick_data_x;
            smp_y <= joystick_data_y;
         end
         if (state == CALC) begin
            pos_col <= pend ? COL_CTR : col_nx;
            pos_row <= pend ? ROW_CTR : row_nx;
         end
         if (recenter) begin
            pend <= 1'b1;
         end else if (state == CALC) begin
            pend <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_logo_mover.sv
// Directed bench for logo_mover with a frame-level reference model.
module tb_logo_mover;
   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        v_sync = 1'b1;
   logic [11:0] jx = 12'd2048;
   logic [11:0] jy = 12'd2048;
   logic        move_en = 1'b1;
   logic        recenter = 1'b0;
   logic [9:0]  pos_col;
   logic [8:0]  pos_row;
   logic        upd_o;

   int errors = 0;
   int checks = 0;
   int pulses = 0;

   int m_col = 256;
   int m_row = 176;
   int m_upd = 0;
   int m_pend = 0;
   int m_vprev = 1;
   int m_cnt = 0;
   int m_sx = 2048;
   int m_sy = 2048;

   logo_mover dut (
      .clk(clk), .arst(arst), .v_sync(v_sync),
      .joystick_data_x(jx), .joystick_data_y(jy),
      .move_en(move_en), .recenter(recenter),
      .pos_col(pos_col), .pos_row(pos_row), .upd_o(upd_o)
   );

   always #20 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int stepv(input int s);
      int d;
      d = s - 2048;
      if (d <= 256 && d >= -256) return 0;
      if (d >= 0) return d / 256;
      return -((-d + 255) / 256);
   endfunction

   function automatic int fit(input int v, input int mx);
`ifdef LOGO_MOVER_WRAP_EN
      if (v < 0) return v + mx + 1;
      if (v > mx) return v - mx - 1;
      return v;
`else
      if (v < 0) return 0;
      if (v > mx) return mx;
      return v;
`endif
   endfunction

   // Reference: per cycle, check then advance using this cycle's inputs.
   always @(negedge clk) begin
      if (arst) begin
         m_col = 256; m_row = 176; m_upd = 0;
         m_pend = 0; m_vprev = 1; m_cnt = 0;
      end
      chk("pos_col", int'(pos_col), m_col);
      chk("pos_row", int'(pos_row), m_row);
      chk("upd_o", int'(upd_o), m_upd);
      if (upd_o) pulses++;
      if (!arst) begin
         m_upd = (m_cnt == 2) ? 1 : 0;
         if (m_cnt == 1) begin
            m_sx = int'(jx);
            m_sy = int'(jy);
         end
         if (m_cnt == 2) begin
            if (m_pend != 0) begin
               m_col = 256; m_row = 176; m_pend = 0;
            end else if (move_en) begin
               m_col = fit(m_col + stepv(m_sx), 512);
               m_row = fit(m_row - stepv(m_sy), 352);
            end
         end
         if (recenter) m_pend = 1;
         if (m_cnt == 0) begin
            if (m_vprev == 1 && v_sync == 1'b0) m_cnt = 1;
         end else begin
            m_cnt = (m_cnt == 3) ? 0 : m_cnt + 1;
         end
         m_vprev = int'(v_sync);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [11:0] x, input logic [11:0] y,
                        input bit rc_upd, input bit rst2, input bit dbl);
      jx = x; jy = y; v_sync = 1'b0;
      cyc();
      v_sync = 1'b1;
      cyc();
      chk("upd_at_n2", int'(upd_o), 0);
      jx = 12'hABC; jy = 12'h123;
      if (dbl) v_sync = 1'b0;
      if (rst2) arst = 1'b1;
      cyc();
      chk("upd_at_n3", int'(upd_o), rst2 ? 0 : 1);
      v_sync = 1'b1;
      if (rc_upd) recenter = 1'b1;
      cyc();
      recenter = 1'b0;
      arst = 1'b0;
      repeat (3) cyc();
   endtask

   task automatic lit(input string nm, input int c, input int r);
      chk({nm, "_col"}, int'(pos_col), c);
      chk({nm, "_row"}, int'(pos_row), r);
   endtask

   initial begin
      int p0;
      repeat (3) cyc();
      arst = 1'b0;
      cyc();
      lit("reset", 256, 176);
      frame(12'd2048, 12'd2048, 0, 0, 0);
      lit("centre", 256, 176);
      frame(12'd4095, 12'd2048, 0, 0, 0);
      lit("xmax", 263, 176);
      frame(12'd2304, 12'd1792, 0, 0, 0);
      lit("dz_edge", 263, 176);
      frame(12'd1791, 12'd2048, 0, 0, 0);
      lit("dz_neg", 261, 176);
      frame(12'd4095, 12'd2048, 0, 0, 1);
      lit("dbl_tick", 268, 176);
      frame(12'd4095, 12'd2048, 1, 0, 0);
      lit("rc_same", 275, 176);
      frame(12'd4095, 12'd2048, 0, 0, 0);
      lit("rc_next", 256, 176);
      for (int i = 1; i <= 30; i++) begin
         frame(12'd2048, 12'd0, 0, 0, 0);
         if (i == 1 || i == 22 || i == 23 || i == 30)
            lit("ydown", 256, (176 + 8 * i > 352) ? 352 : 176 + 8 * i);
      end
      move_en = 1'b0;
      p0 = pulses;
      for (int i = 0; i < 5; i++) frame(12'd0, 12'd2048, 0, 0, 0);
      lit("frozen", 256, 352);
      chk("frozen_pulses", pulses - p0, 5);
      p0 = pulses;
      frame(12'd0, 12'd2048, 0, 1, 0);
      chk("rst_pulses", pulses - p0, 0);
      lit("rst_mid", 256, 176);
      move_en = 1'b1;
      frame(12'd4095, 12'd2048, 0, 0, 0);
      lit("after_rst", 263, 176);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
